// File: rtl/mul_pkg.sv
// Shared encodings and defaults for the repeated-addition multiplier control path.
package mul_pkg;

    localparam int STATE_W      = 3;
    localparam int CNT_W_DEF    = 16;
    localparam int MAX_ITER_DEF = 65535;

    localparam logic [STATE_W-1:0] ENC_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ENC_LOAD_A = 3'd1;
    localparam logic [STATE_W-1:0] ENC_LOAD_B = 3'd2;
    localparam logic [STATE_W-1:0] ENC_CALC   = 3'd3;
    localparam logic [STATE_W-1:0] ENC_DONE   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = ENC_IDLE,
        LOAD_A = ENC_LOAD_A,
        LOAD_B = ENC_LOAD_B,
        CALC   = ENC_CALC,
        DONE   = ENC_DONE
    } state_t;

endpackage

// File: rtl/mul_ctrl_if.sv
// Host handshake plus datapath strobes of the multiplier control path.
// master = host/datapath side, slave = controller side.
interface mul_ctrl_if;

    logic start;
    logic abort;
    logic eqz;
    logic ldA;
    logic ldB;
    logic ldP;
    logic clrP;
    logic decB;
    logic busy;
    logic done;
    logic err;

    modport master (
        output start, abort, eqz,
        input  ldA, ldB, ldP, clrP, decB, busy, done, err
    );

    modport slave (
        input  start, abort, eqz,
        output ldA, ldB, ldP, clrP, decB, busy, done, err
    );

endinterface

// File: rtl/mul_iter_cnt.sv
// Iteration counter for the CALC loop: sync clear, enable, and a terminal
// flag at MAX_ITER-1. The count never advances past the terminal value.
module mul_iter_cnt #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_ITER - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == LAST);

    // Count up while enabled, holding at the terminal value instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mul_ctrl.sv
// Control path for the 16-bit repeated-addition multiplier (P = A * B).
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; all outputs low, iteration count cleared
//   LOAD_A | ldA for one cycle (A from data bus)
//   LOAD_B | ldB + clrP for one cycle (B from data bus, P cleared)
//   CALC   | P <= P + A and B-- each cycle B != 0; exits on eqz or limit
//   DONE   | product valid, err valid; waits for start to drop
//
// ldP/decB are the only Mealy outputs (qualified by eqz in CALC), so they
// are never asserted alongside the registered ldA/ldB/clrP strobes.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_ctrl_if.slave  bus
);

    state_t state;
    logic   lda_q;
    logic   ldb_q;
    logic   clrp_q;
    logic   busy_q;
    logic   done_q;
    logic   err_q;
    logic   in_calc;
    logic   iter_clr;
    logic   iter_en;
    logic   iter_tc;

    assign iter_clr = (state == IDLE);
    assign iter_en  = in_calc && !bus.eqz && !bus.abort;

    mul_iter_cnt #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (iter_clr),
        .en    (iter_en),
        .tc    (iter_tc)
    );

    // State register, transitions and registered output decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lda_q   <= 1'b0;
            ldb_q   <= 1'b0;
            clrp_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            in_calc <= 1'b0;
        end else begin
            lda_q  <= 1'b0;
            ldb_q  <= 1'b0;
            clrp_q <= 1'b0;
            case (state)
                IDLE: begin
                    // start beats a simultaneous abort here
                    if (bus.start) begin
                        state  <= LOAD_A;
                        lda_q  <= 1'b1;
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                    end
                end
                LOAD_A: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state  <= LOAD_B;
                        ldb_q  <= 1'b1;
                        clrp_q <= 1'b1;
                    end
                end
                LOAD_B: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state   <= CALC;
                        in_calc <= 1'b1;
                    end
                end
                CALC: begin
                    if (bus.abort) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        in_calc <= 1'b0;
                    end else if (bus.eqz || iter_tc) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        in_calc <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= !bus.eqz;
                    end
                end
                DONE: begin
                    // err drops with done so IDLE presents all-zero outputs
                    if (!bus.start) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    in_calc <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ldA  = lda_q;
    assign bus.ldB  = ldb_q;
    assign bus.clrP = clrp_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.ldP  = in_calc && !bus.eqz;
    assign bus.decB = in_calc && !bus.eqz;

endmodule
